// File: rtl/alarm_controller.sv
// Intrusion-alarm controller: away/stay arming, exit/entry delay timers,
// latched alarm cleared only by disarm, and a snapshot of the tripping zones.
module alarm_controller #(
    parameter int N_DOORS   = 2,
    parameter int N_WINDOWS = 3,
    parameter int EXIT_DLY  = 8,
    parameter int ENTRY_DLY = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           arm_away,
    input  logic                           arm_stay,
    input  logic                           disarm,
    input  logic [N_DOORS-1:0]             doors,
    input  logic [N_WINDOWS-1:0]           windows,
    output logic                           alarm,
    output logic                           secure,
    output logic                           armed,
    output logic                           exit_pending,
    output logic                           entry_pending,
    output logic                           ready,
    output logic [N_WINDOWS+N_DOORS-1:0]   trip_zones,
    output logic [2:0]                     state
);

    localparam int MAX_DLY = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
    localparam int CW      = $clog2(MAX_DLY + 1);

    localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_DLY - 1);
    localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DLY - 1);

    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_EXIT     = 3'd1;
    localparam logic [2:0] S_AWAY     = 3'd2;
    localparam logic [2:0] S_STAY     = 3'd3;
    localparam logic [2:0] S_ENTRY    = 3'd4;
    localparam logic [2:0] S_ALARM    = 3'd5;

    logic [2:0]                   st, st_nxt;
    logic [CW-1:0]                cnt, cnt_nxt;
    logic [N_WINDOWS+N_DOORS-1:0] trip_nxt;
    logic                         any_win, any_door;

    assign any_win  = |windows;
    assign any_door = |doors;
    assign ready    = ~any_win & ~any_door;

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        trip_nxt = trip_zones;
        if (disarm) begin
            st_nxt = S_DISARMED;
        end else begin
            case (st)
                S_DISARMED: begin
                    // arm_stay outranks arm_away even when it is rejected
                    if (arm_stay) begin
                        if (ready) begin
                            st_nxt   = S_STAY;
                            trip_nxt = '0;
                        end
                    end else if (arm_away) begin
                        st_nxt   = S_EXIT;
                        cnt_nxt  = EXIT_LOAD;
                        trip_nxt = '0;
                    end
                end
                S_EXIT: begin
                    if (cnt == '0) begin
                        if (any_win) begin
                            st_nxt   = S_ALARM;
                            trip_nxt = {windows, doors};
                        end else if (any_door) begin
                            st_nxt  = S_ENTRY;
                            cnt_nxt = ENTRY_LOAD;
                        end else begin
                            st_nxt = S_AWAY;
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                S_AWAY: begin
                    if (any_win) begin
                        st_nxt   = S_ALARM;
                        trip_nxt = {windows, doors};
                    end else if (any_door) begin
                        st_nxt  = S_ENTRY;
                        cnt_nxt = ENTRY_LOAD;
                    end
                end
                S_STAY: begin
                    if (any_win || any_door) begin
                        st_nxt   = S_ALARM;
                        trip_nxt = {windows, doors};
                    end
                end
                S_ENTRY: begin
                    if (any_win || cnt == '0) begin
                        st_nxt   = S_ALARM;
                        trip_nxt = {windows, doors};
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                S_ALARM: st_nxt = S_ALARM;
                default: begin
                    st_nxt  = S_DISARMED;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // Status outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= S_DISARMED;
            state         <= S_DISARMED;
            cnt           <= '0;
            trip_zones    <= '0;
            alarm         <= 1'b0;
            secure        <= 1'b1;
            armed         <= 1'b0;
            exit_pending  <= 1'b0;
            entry_pending <= 1'b0;
        end else begin
            st            <= st_nxt;
            state         <= st_nxt;
            cnt           <= cnt_nxt;
            trip_zones    <= trip_nxt;
            alarm         <= (st_nxt == S_ALARM);
            secure        <= ~((st_nxt == S_ENTRY) || (st_nxt == S_ALARM));
            armed         <= (st_nxt == S_AWAY) || (st_nxt == S_STAY) || (st_nxt == S_ENTRY);
            exit_pending  <= (st_nxt == S_EXIT);
            entry_pending <= (st_nxt == S_ENTRY);
        end
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequential, parametrised intrusion-alarm controller for the lab alarm subsystem. It supports any number of door and window zones and two arming modes: away and stay. It adds exit and entry delay timers, a latched alarm state that is cleared only by an explicit disarm, and a record of which zones tripped. It sits between the keypad command decoder (single-cycle command pulses) and the siren/indicator drivers.

## Interface
Parameters:
- N_DOORS, 2: number of door zones (≥1).
- N_WINDOWS, 3: number of window zones (≥1).
- EXIT_DLY, 8: exit-delay length in clock cycles (≥1).
- ENTRY_DLY, 8: entry-delay length in clock cycles (≥1).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- arm_away  in  1  one-cycle command pulse: arm in away mode.
- arm_stay  in  1  one-cycle command pulse: arm in stay mode.
- disarm  in  1  one-cycle command pulse: disarm or clear the alarm.
- doors  in  N_DOORS  1 = door open.
- windows  in  N_WINDOWS  1 = window open.
- alarm  out  1  registered; 1 iff state is ALARM.
- secure  out  1  registered; 0 iff state is ENTRY or ALARM.
- armed  out  1  registered; 1 in AWAY, STAY or ENTRY.
- exit_pending  out  1  registered; 1 in EXIT.
- entry_pending  out  1  registered; 1 in ENTRY.
- ready  out  1  combinational; 1 iff no door and no window is open.
- trip_zones  out  N_WINDOWS+N_DOORS  registered; the {windows,doors} snapshot latched on entry to ALARM.
- state  out  3  registered state code.

## Operation
- States and codes: DISARMED=0, EXIT=1, AWAY=2, STAY=3, ENTRY=4, ALARM=5. Codes 6 and 7 are illegal and return to DISARMED on the next edge.
- Reset sets state to DISARMED, cnt to 0 and trip_zones to 0. Outputs after reset: alarm=0, secure=1, armed=0, exit_pending=0, entry_pending=0.
- Command priority within one cycle: disarm > arm_stay > arm_away.
- disarm moves any state to DISARMED on the next edge and clears nothing else. trip_zones is held for inspection.
- Arm commands are ignored outside DISARMED.
- DISARMED:
  - arm_stay with ready=1 → STAY. arm_stay with ready=0 is rejected and the state stays DISARMED.
  - arm_away → EXIT regardless of ready. cnt loads EXIT_DLY-1. trip_zones clears to 0.
  - arm_stay accepted also clears trip_zones.
- EXIT:
  - All zones are ignored.
  - cnt decrements each cycle.
  - When cnt==0, the state evaluates zones in the same cycle: any window open → ALARM; else any door open → ENTRY (cnt loads ENTRY_DLY-1); else → AWAY.
- AWAY:
  - Any window open → ALARM, with no delay.
  - Else any door open → ENTRY, with cnt loaded to ENTRY_DLY-1.
- STAY: any door or window open → ALARM, with no delay.
- ENTRY:
  - disarm → DISARMED.
  - Else any window open → ALARM immediately.
  - Else cnt==0 → ALARM.
  - Else cnt decrements.
  - Doors closing does not cancel the delay.
- ALARM: latched. Closing zones has no effect. Only disarm or reset leaves this state.
- trip_zones is written with {windows,doors} on the edge that enters ALARM, and only on that edge.
- cnt width is $clog2(max(EXIT_DLY,ENTRY_DLY)+1). cnt never underflows.

## Timing
- Commands and zones are sampled at rising edge k. The new state and all registered outputs are valid after edge k.
- EXIT lasts exactly EXIT_DLY cycles: if arm_away is sampled at edge k, the AWAY, ENTRY or ALARM decision is taken at edge k+EXIT_DLY.
- ENTRY lasts exactly ENTRY_DLY cycles unless it is preempted. A disarm sampled at edge k+ENTRY_DLY-1 or earlier still prevents the alarm. At edge k+ENTRY_DLY, ALARM is entered.
- Zone → ALARM latency in STAY, or for a window in AWAY: 1 edge.
- reset asserted in any state overrides every command on that edge, including mid-delay and during ALARM.
- ready has zero latency from the zone inputs and is not registered.

## Test plan
- Reset, then arm_stay with all zones closed, then doors=2'b01 → state 3, then 5 one edge after the door opens. alarm=1, secure=0, trip_zones=5'b00001.
- EXIT_DLY=8: arm_away at edge 0, window opened at edge 3 and closed at edge 5 → exit_pending=1 for edges 0..7, state=2 after edge 8, alarm stays 0.
- AWAY, door opened at edge 0, ENTRY_DLY=8, disarm at edge 7 → entry_pending=1 and secure=0 for edges 0..6, state=0 after edge 7, alarm never asserts. Repeat without disarm: alarm=1 after edge 8.
- ENTRY in progress, then windows=3'b100 → ALARM on the next edge, before the timer expires. All zones closed afterwards leaves alarm=1 until disarm.
- arm_stay with doors=2'b10 → rejected, state stays 0. arm_stay, arm_away and disarm in the same cycle → state 0. arm_stay and arm_away together with ready=1 → state 3.
- Force state code 6 via an illegal-state check → state is 0 on the next edge. reset asserted during ALARM → all outputs return to reset values on the next edge.
